// File: rtl/tinker_fetch_pkg.sv
// Shared types and constants for the tinker instruction fetch front-end.
package tinker_fetch_pkg;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_FAULT = 2'd2
    } fetch_state_t;

    localparam int          INSTR_BYTES      = 4;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h2000;

endpackage

// File: rtl/tinker_fetch_fifo.sv
// Prefetch FIFO of {instruction word, pc}; head and count come straight from registers.
module fetch_fifo #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             push,
    input  logic [31:0]      push_word,
    input  logic [63:0]      push_pc,
    input  logic             pop,
    output logic             head_valid,
    output logic [31:0]      head_word,
    output logic [63:0]      head_pc,
    output logic [CNT_W-1:0] count
);

    logic [31:0]      word_mem [DEPTH];
    logic [63:0]      pc_mem   [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // A full FIFO may still accept a push when the head leaves in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                word_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                word_mem[wr_ptr] <= push_word;
                pc_mem[wr_ptr]   <= push_pc;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    assign head_valid = (count != '0);
    assign head_word  = word_mem[rd_ptr];
    assign head_pc    = pc_mem[rd_ptr];

endmodule

// File: rtl/tinker_fetch_unit.sv
// Instruction fetch front-end: credit-limited memory reads into a prefetch FIFO.
// Optional TINKER_FETCH_ALIGN_CHECK_EN halts on a misaligned redirect and exposes fetch_fault.
module tinker_fetch_unit
    import tinker_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC        = DEFAULT_RESET_PC,
    parameter int          FIFO_DEPTH      = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [63:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_word,
    output logic [63:0] inst_pc
`ifdef TINKER_FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_fault
`endif
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    fetch_state_t     state;
    fetch_state_t     state_next;
    logic [63:0]      fetch_pc;
    logic [63:0]      resp_pc;
    logic [63:0]      redirect_pc_aligned;
    logic [OUT_W-1:0] outstanding;
    logic [OUT_W-1:0] drop_cnt;
    logic [OUT_W-1:0] drop_cnt_next;
    logic [OUT_W-1:0] drop_on_redirect;
    logic [CNT_W-1:0] fifo_count;
    logic             credit_ok;
    logic             req_accept;
    logic             resp_ok;
    logic             redirect_hit;
    logic             fifo_push;
    logic             fifo_pop;

    // Credit uses only registered counts so inst_ready never reaches mem_req_valid.
    assign credit_ok = ((32'(fifo_count) + 32'(outstanding)) < 32'(FIFO_DEPTH))
                    && (32'(outstanding) < 32'(MAX_OUTSTANDING));

    assign mem_req_valid = !reset && (state == S_RUN) && credit_ok;
    assign mem_req_addr  = fetch_pc;
    assign req_accept    = mem_req_valid && mem_req_ready;

    assign resp_ok             = mem_resp_valid && (outstanding != '0);
    assign redirect_hit        = redirect_valid && (state != S_FAULT);
    assign redirect_pc_aligned = redirect_pc & ~64'h3;
    assign drop_on_redirect    = outstanding + OUT_W'(req_accept) - OUT_W'(resp_ok);

    assign fifo_push = resp_ok && (state == S_RUN) && !redirect_valid;
    assign fifo_pop  = inst_valid && inst_ready;

    always_comb begin
        state_next    = state;
        drop_cnt_next = drop_cnt;
        case (state)
            S_RUN, S_DRAIN: begin
                if (redirect_valid) begin
                    drop_cnt_next = drop_on_redirect;
                    state_next    = (drop_on_redirect != '0) ? S_DRAIN : S_RUN;
`ifdef TINKER_FETCH_ALIGN_CHECK_EN
                    if (redirect_pc[1:0] != 2'b00) begin
                        state_next    = S_FAULT;
                        drop_cnt_next = '0;
                    end
`endif
                end else if ((state == S_DRAIN) && resp_ok) begin
                    drop_cnt_next = drop_cnt - OUT_W'(1);
                    if (drop_cnt == OUT_W'(1)) begin
                        state_next = S_RUN;
                    end
                end
            end
`ifdef TINKER_FETCH_ALIGN_CHECK_EN
            S_FAULT: state_next = S_FAULT;
`endif
            default: state_next = S_RUN;
        endcase
    end

    // resp_pc tracks the address of the oldest live request, so no tag queue is needed.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_RUN;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state       <= state_next;
            drop_cnt    <= drop_cnt_next;
            outstanding <= outstanding + OUT_W'(req_accept) - OUT_W'(resp_ok);
            if (redirect_hit) begin
                fetch_pc <= redirect_pc_aligned;
                resp_pc  <= redirect_pc_aligned;
            end else begin
                if (req_accept) begin
                    fetch_pc <= fetch_pc + 64'(INSTR_BYTES);
                end
                if (fifo_push) begin
                    resp_pc <= resp_pc + 64'(INSTR_BYTES);
                end
            end
        end
    end

`ifdef TINKER_FETCH_ALIGN_CHECK_EN
    assign fetch_fault = (state == S_FAULT);
`endif

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .clear      (redirect_hit),
        .push       (fifo_push),
        .push_word  (mem_resp_data),
        .push_pc    (resp_pc),
        .pop        (fifo_pop),
        .head_valid (inst_valid),
        .head_word  (inst_word),
        .head_pc    (inst_pc),
        .count      (fifo_count)
    );

endmodule

// File: tb/tb_tinker_fetch_unit.sv
// Randomized bench for tinker_fetch_unit against an address-stream and occupancy reference model.
module tb_tinker_fetch_unit;
    import tinker_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [63:0] mem_req_addr;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_word;
    logic [63:0] inst_pc;
`ifdef TINKER_FETCH_ALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    always #5 clk = ~clk;

    tinker_fetch_unit dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_word      (inst_word),
        .inst_pc        (inst_pc)
`ifdef TINKER_FETCH_ALIGN_CHECK_EN
        ,
        .fetch_fault    (fetch_fault)
`endif
    );

    int          total = 0;
    int          bad   = 0;
    int          req_pct;
    int          resp_pct;
    int          inst_pct;
    bit          ghost;
    bit          resp_real;
    logic [63:0] q_addr[$];
    int          q_epoch[$];
    int          epoch;
    int          occ;
    bit          halted;
    logic [63:0] exp_req;
    logic [63:0] exp_pc;
    logic [63:0] rand_tgt;

    // Memory contents are a fixed function of the address so every word is traceable.
    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5EED_1234;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyReset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        inst_ready     = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst_word", inst_word, 0);
        chk("rst_inst_pc", inst_pc, 0);
`ifdef TINKER_FETCH_ALIGN_CHECK_EN
        chk("rst_fault", fetch_fault, 0);
`endif
        reset = 1'b0;
        q_addr.delete();
        q_epoch.delete();
        epoch++;
        occ     = 0;
        halted  = 1'b0;
        exp_req = DEFAULT_RESET_PC;
        exp_pc  = DEFAULT_RESET_PC;
    endtask

    // Memory answers strictly in order, never in the same cycle as the accept.
    task automatic applyStimulus(input bit redir, input logic [63:0] target);
        mem_req_ready  = ($urandom_range(99) < req_pct);
        inst_ready     = ($urandom_range(99) < inst_pct);
        redirect_valid = redir;
        redirect_pc    = target;
        resp_real      = 1'b0;
        if ((q_addr.size() > 0) && ($urandom_range(99) < resp_pct)) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = word_of(q_addr[0]);
            resp_real      = 1'b1;
        end else if (ghost) begin
            mem_resp_valid = 1'b1;
            mem_resp_data  = $urandom;
        end else begin
            mem_resp_valid = 1'b0;
            mem_resp_data  = $urandom;
        end
    endtask

    task automatic checkOutput();
        int stale;
        bit exp_valid;
        stale = 0;
        foreach (q_epoch[i]) if (q_epoch[i] != epoch) stale++;
        exp_valid = !halted && (stale == 0) && ((occ + q_addr.size()) < 4) && (q_addr.size() < 2);
        chk("req_valid", mem_req_valid, exp_valid);
        if (exp_valid) chk("req_addr", mem_req_addr, exp_req);
        chk("inst_valid", inst_valid, occ > 0);
`ifdef TINKER_FETCH_ALIGN_CHECK_EN
        chk("fault", fetch_fault, halted);
`endif
        if ((occ > 0) && inst_ready) begin
            chk("inst_pc", inst_pc, exp_pc);
            chk("inst_word", inst_word, word_of(exp_pc));
            exp_pc += 64'd4;
            occ--;
        end
        if (exp_valid && mem_req_ready) begin
            q_addr.push_back(exp_req);
            q_epoch.push_back(epoch);
            exp_req += 64'd4;
        end
        if (resp_real) begin
            if ((q_epoch[0] == epoch) && !redirect_valid) occ++;
            void'(q_addr.pop_front());
            void'(q_epoch.pop_front());
        end
        if (redirect_valid && !halted) begin
            occ = 0;
            epoch++;
`ifdef TINKER_FETCH_ALIGN_CHECK_EN
            if (redirect_pc[1:0] != 2'b00) halted = 1'b1;
`endif
            exp_req = redirect_pc & ~64'h3;
            exp_pc  = redirect_pc & ~64'h3;
        end
    endtask

    task automatic stepCycle(input bit redir, input logic [63:0] target);
        applyStimulus(redir, target);
        #1;
        checkOutput();
        @(negedge clk);
    endtask

    initial begin
        ghost    = 1'b0;
        epoch    = 0;
        req_pct  = 100;
        resp_pct = 100;
        inst_pct = 100;
        $display("[TB] start");
        applyReset();

        // Full-rate streaming from RESET_PC.
        repeat (12) stepCycle(1'b0, '0);

        // Decoder stalled: FIFO fills, issue stops; one pop frees exactly one slot.
        inst_pct = 0;
        repeat (10) stepCycle(1'b0, '0);
        inst_pct = 100;
        stepCycle(1'b0, '0);
        inst_pct = 0;
        repeat (5) stepCycle(1'b0, '0);

        // Memory refuses requests: valid and address must hold.
        applyReset();
        inst_pct = 100;
        req_pct  = 0;
        repeat (6) stepCycle(1'b0, '0);
        req_pct = 100;

        // Redirect with two outstanding and a response in the same cycle.
        resp_pct = 0;
        repeat (3) stepCycle(1'b0, '0);
        resp_pct = 100;
        stepCycle(1'b1, 64'h3000);
        repeat (10) stepCycle(1'b0, '0);

        // Redirect coinciding with an instruction handshake.
        inst_pct = 0;
        for (int i = 0; (i < 20) && (occ == 0); i++) stepCycle(1'b0, '0);
        chk("fill_bound", occ > 0, 1);
        inst_pct = 100;
        stepCycle(1'b1, 64'h4000);
        repeat (8) stepCycle(1'b0, '0);

        // Randomized traffic with occasional redirects, including 64-bit wrap.
        for (int n = 0; n < 400; n++) begin
            if ((n % 25) == 0) begin
                req_pct  = 30 + int'($urandom_range(70));
                resp_pct = 20 + int'($urandom_range(80));
                inst_pct = int'($urandom_range(100));
            end
            if ($urandom_range(99) < 4) begin
                rand_tgt = {$urandom, $urandom} & ~64'h3;
                if ($urandom_range(3) == 0) rand_tgt = 64'hFFFF_FFFF_FFFF_FFF0;
                stepCycle(1'b1, rand_tgt);
            end else begin
                stepCycle(1'b0, '0);
            end
        end

        // Reset mid-traffic, then a response nobody asked for.
        applyReset();
        req_pct  = 100;
        resp_pct = 100;
        inst_pct = 100;
        ghost    = 1'b1;
        stepCycle(1'b0, '0);
        ghost = 1'b0;
        repeat (6) stepCycle(1'b0, '0);

        // Misaligned redirect: aligned fetch, or a sticky fault when the check is built in.
        stepCycle(1'b1, 64'h3002);
        repeat (8) stepCycle(1'b0, '0);
        applyReset();
        repeat (4) stepCycle(1'b0, '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
